// File: rtl/bin_seq_source_pkg.sv
// Shared types and helpers for the binary sequence source: state encoding,
// default width and the count-step / terminal-value functions.
package bin_seq_source_pkg;

  localparam int DEFAULT_WIDTH = 4;
  localparam int MAX_WIDTH     = 32;

  typedef logic [MAX_WIDTH-1:0] val_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic val_t width_mask(input int width);
    return {MAX_WIDTH{1'b1}} >> (MAX_WIDTH - width);
  endfunction

  // One count step in the chosen direction, wrapping modulo 2^width.
  function automatic val_t next_val(input val_t val, input logic dir,
                                    input int width = DEFAULT_WIDTH);
    val_t w_raw;
    w_raw = dir ? (val - val_t'(1)) : (val + val_t'(1));
    return w_raw & width_mask(width);
  endfunction

  function automatic logic is_terminal(input val_t val, input logic dir,
                                       input int width = DEFAULT_WIDTH);
    return dir ? ((val & width_mask(width)) == '0)
               : ((val & width_mask(width)) == width_mask(width));
  endfunction

endpackage

// File: rtl/bin_seq_source.sv
// Registered up/down binary sequence source with valid/ready handshake,
// wrap or one-shot mode and a terminal-count pulse for sequence framing.
module bin_seq_source
  import bin_seq_source_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             dir,
  input  logic             oneshot,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] BIN,
  output logic             valid,
  input  logic             ready,
  output logic             tc,
  output logic             busy
);

  state_e           r_state;
  state_e           w_state_next;
  logic [WIDTH-1:0] r_bin;
  logic [WIDTH-1:0] w_bin_next;
  logic [WIDTH-1:0] w_bin_step;
  logic             r_tc;
  logic             w_tc_next;
  logic             w_xfer;
  logic             w_term;

  assign w_xfer     = (r_state == ST_RUN) && ready;
  assign w_term     = is_terminal(val_t'(r_bin), dir, WIDTH);
  assign w_bin_step = WIDTH'(next_val(val_t'(r_bin), dir, WIDTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_bin   <= '0;
      r_tc    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_bin   <= w_bin_next;
      r_tc    <= w_tc_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_bin_next   = r_bin;
    w_tc_next    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        // A simultaneous start is dropped so the freshly loaded value is never raced.
        if (load) begin
          w_bin_next = load_val;
        end else if (start) begin
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_xfer) begin
          if (w_term) begin
            w_tc_next = 1'b1;
            if (oneshot) begin
              w_state_next = ST_DONE;
            end else begin
              w_bin_next = w_bin_step;
            end
          end else begin
            w_bin_next = w_bin_step;
          end
        end
        // Abort overrides DONE, but the transfer of this cycle still completes.
        if (stop) begin
          w_state_next = ST_IDLE;
        end
      end
      ST_DONE: begin
        if (load) begin
          w_bin_next   = load_val;
          w_state_next = ST_IDLE;
        end else if (stop) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    BIN   = r_bin;
    tc    = r_tc;
    valid = (r_state == ST_RUN);
    busy  = (r_state == ST_RUN);
  end

endmodule
